// File: rtl/xy_route_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : xy_route_arbiter
// Description : Switch stage of one mesh node. Reads the five input-queue
//               heads, computes each head's XY dimension-order output port,
//               round-robin arbitrates per output port, pops the winning
//               queue and registers the packet toward the neighbour queue.
//               Sustains one packet per output port per cycle.
//
// Ports       : clk        clock
//               rst_n      asynchronous active-low reset
//               in_data    5 queue heads, slice i = in_data[i*PL +: PL]
//               in_shift   pop strobe to queue i (combinational, same cycle)
//               out_data   5 registered output slots, slice o = out_data[o*PL +: PL]
//               out_avail  downstream queue o can capture on this edge
//
// Port index  : 0=Local 1=North 2=East 3=South 4=West
// Packet      : bit 0 valid, bits COORD_W..1 dest X, bits 2*COORD_W..COORD_W+1
//               dest Y, remaining bits payload (passed through untouched)
//
// Revision    : 1.0 - initial release
// ============================================================================
module xy_route_arbiter #(
    parameter int PL      = 64,
    parameter int COORD_W = 2,
    parameter int X_POS   = 0,
    parameter int Y_POS   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5*PL-1:0] in_data,
    output logic [4:0]      in_shift,
    output logic [5*PL-1:0] out_data,
    input  logic [4:0]      out_avail
);

    localparam logic [2:0]         c_port_local = 3'd0;
    localparam logic [2:0]         c_port_north = 3'd1;
    localparam logic [2:0]         c_port_east  = 3'd2;
    localparam logic [2:0]         c_port_south = 3'd3;
    localparam logic [2:0]         c_port_west  = 3'd4;
    localparam logic [2:0]         c_rr_reset   = 3'd4;
    localparam logic [COORD_W-1:0] c_x_pos      = COORD_W'(X_POS);
    localparam logic [COORD_W-1:0] c_y_pos      = COORD_W'(Y_POS);

    logic [PL-1:0]   w_heads [5];
    logic [4:0]      w_head_valid;
    logic [4:0][2:0] w_route;
    logic [4:0][4:0] w_gnt_mat;     // [output][input] one-hot grants

    // ------------------------------------------------------------------
    // Per-input XY route computation (unsigned compares)
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 5; i++) begin : g_in
            logic [COORD_W-1:0] w_dest_x;
            logic [COORD_W-1:0] w_dest_y;
            logic [2:0]         w_sel;

            assign w_heads[i]      = in_data[i*PL +: PL];
            assign w_head_valid[i] = in_data[i*PL];
            assign w_dest_x        = in_data[i*PL+1 +: COORD_W];
            assign w_dest_y        = in_data[i*PL+1+COORD_W +: COORD_W];

            // X is resolved fully before Y is considered.
            always_comb begin
                w_sel = c_port_local;
                if (w_dest_x > c_x_pos)      w_sel = c_port_east;
                else if (w_dest_x < c_x_pos) w_sel = c_port_west;
                else if (w_dest_y > c_y_pos) w_sel = c_port_south;
                else if (w_dest_y < c_y_pos) w_sel = c_port_north;
            end

            assign w_route[i] = w_sel;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-output arbitration and output slot register
    // ------------------------------------------------------------------
    generate
        for (genvar o = 0; o < 5; o++) begin : g_out
            logic [PL-1:0] r_slot;
            logic [2:0]    r_rr;        // last granted input, 0..4
            logic [4:0]    w_req;
            logic          w_slot_free;
            logic          w_gnt_any;
            logic [2:0]    w_gnt_idx;

            always_comb begin
                for (int i = 0; i < 5; i++) begin
                    w_req[i] = w_head_valid[i] && (w_route[i] == 3'(o));
                end
            end

            // The slot can take a new packet if it is empty or is being
            // drained by the downstream queue on this same edge.
            assign w_slot_free = !r_slot[0] || out_avail[o];

            // Scan from lowest to highest priority (rr+5 down to rr+1) so
            // the highest-priority requester is the last one written.
            always_comb begin
                logic [3:0] w_cand;
                w_gnt_any = 1'b0;
                w_gnt_idx = r_rr;
                w_cand    = 4'd0;
                for (int k = 5; k >= 1; k--) begin
                    w_cand = {1'b0, r_rr} + 4'(k);
                    if (w_cand >= 4'd5) begin
                        w_cand = w_cand - 4'd5;
                    end
                    if (w_req[w_cand[2:0]]) begin
                        w_gnt_any = 1'b1;
                        w_gnt_idx = w_cand[2:0];
                    end
                end
                if (!w_slot_free) begin
                    w_gnt_any = 1'b0;
                end
            end

            assign w_gnt_mat[o] = w_gnt_any ? (5'b00001 << w_gnt_idx) : 5'b00000;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_slot <= '0;
                    r_rr   <= c_rr_reset;
                end else if (w_gnt_any) begin
                    r_slot <= w_heads[w_gnt_idx];
                    r_rr   <= w_gnt_idx;
                end else if (out_avail[o]) begin
                    // Accepted (or already empty) with nothing new to load.
                    r_slot <= '0;
                end
            end

            assign out_data[o*PL +: PL] = r_slot;
        end
    endgenerate

    // Each input requests exactly one output, so at most one grant per
    // input; the OR only gathers it. Held low throughout reset.
    always_comb begin
        in_shift = 5'b00000;
        if (rst_n) begin
            for (int o = 0; o < 5; o++) begin
                in_shift = in_shift | w_gnt_mat[o];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xy_route_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_xy_route_arbiter
// Description : Randomised scoreboard bench for xy_route_arbiter at node
//               (1,1). Source queues and a reference switch model live in
//               the bench; expected packets are queued per output on grant
//               and popped by a monitor when the DUT hands a packet over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xy_route_arbiter;

    localparam int PL = 64;
    localparam int CW = 2;
    localparam int NP = 5;
    localparam int XP = 1;
    localparam int YP = 1;

    typedef logic [PL-1:0] pkt_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [NP*PL-1:0] in_data   = '0;
    logic [NP-1:0]    out_avail = '0;
    logic [NP*PL-1:0] out_data;
    logic [NP-1:0]    in_shift;

    xy_route_arbiter #(
        .PL      (PL),
        .COORD_W (CW),
        .X_POS   (XP),
        .Y_POS   (YP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .out_data  (out_data),
        .out_avail (out_avail)
    );

    always #5 clk = ~clk;

    pkt_t srcq   [NP][$];   // bench-side input queues
    pkt_t expq   [NP][$];   // scoreboard: packets expected at each output
    pkt_t m_slot [NP];      // model of the output slots
    int   m_rr   [NP];      // model: last granted input per output

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(string nm, logic [NP*PL-1:0] act, logic [NP*PL-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic pkt_t make_pkt(int dx, int dy);
        pkt_t p;
        p = {$urandom, $urandom};
        p[0]         = 1'b1;
        p[CW:1]      = CW'(dx);
        p[2*CW:CW+1] = CW'(dy);
        return p;
    endfunction

    // XY dimension-order routing: 0=L 1=N 2=E 3=S 4=W
    function automatic int route(pkt_t p);
        int dx;
        int dy;
        dx = int'(p[CW:1]);
        dy = int'(p[2*CW:CW+1]);
        if (dx > XP) return 2;
        if (dx < XP) return 4;
        if (dy > YP) return 3;
        if (dy < YP) return 1;
        return 0;
    endfunction

    task automatic drive_heads();
        for (int i = 0; i < NP; i++) begin
            in_data[i*PL +: PL] = (srcq[i].size() > 0) ? srcq[i][0] : '0;
        end
    endtask

    task automatic model_reset();
        for (int o = 0; o < NP; o++) begin
            m_slot[o] = '0;
            m_rr[o]   = 4;
            expq[o].delete();
        end
    endtask

    // One clock cycle: new arrivals, downstream availability, grant check,
    // then the model advances on the edge.
    task automatic cycle(int arrive_pct, int avail_pct, logic [NP-1:0] off_mask);
        int            win [NP];
        logic [NP-1:0] exp_shift;
        @(negedge clk);
        for (int i = 0; i < NP; i++) begin
            if (($urandom_range(99) < arrive_pct) && (srcq[i].size() < 4)) begin
                srcq[i].push_back(make_pkt($urandom_range(2), $urandom_range(2)));
            end
        end
        for (int o = 0; o < NP; o++) begin
            out_avail[o] = ($urandom_range(99) < avail_pct) && !off_mask[o];
        end
        drive_heads();
        #1;
        exp_shift = '0;
        for (int o = 0; o < NP; o++) begin
            win[o] = -1;
            if (!m_slot[o][0] || out_avail[o]) begin
                for (int k = 1; k <= NP; k++) begin
                    int src;
                    src = (m_rr[o] + k) % NP;
                    if (win[o] < 0 && srcq[src].size() > 0 && route(srcq[src][0]) == o) begin
                        win[o] = src;
                    end
                end
            end
            if (win[o] >= 0) exp_shift[win[o]] = 1'b1;
        end
        chk("in_shift", (NP*PL)'(in_shift), (NP*PL)'(exp_shift));
        @(posedge clk);
        for (int o = 0; o < NP; o++) begin
            if (win[o] >= 0) begin
                m_slot[o] = srcq[win[o]][0];
                expq[o].push_back(m_slot[o]);
                m_rr[o] = win[o];
            end else if (out_avail[o]) begin
                m_slot[o] = '0;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (exp_shift[i]) void'(srcq[i].pop_front());
        end
    endtask

    // Asynchronous reset pulse placed between clock edges; held slots are lost.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-reset out_data", out_data, '0);
        chk("mid-reset in_shift", (NP*PL)'(in_shift), '0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: a packet leaves when its slot is valid and downstream accepts.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                for (int o = 0; o < NP; o++) begin
                    if (out_data[o*PL] && out_avail[o]) begin
                        if (expq[o].size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL out%0d packet: got %h expected none", o, out_data[o*PL +: PL]);
                        end else begin
                            pkt_t e;
                            e = expq[o].pop_front();
                            chk($sformatf("out%0d packet", o), (NP*PL)'(out_data[o*PL +: PL]), (NP*PL)'(e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        bit drained;

        // Reset with valid heads present; all heads target Local.
        model_reset();
        for (int i = 0; i < NP; i++) begin
            repeat (2) srcq[i].push_back(make_pkt(XP, YP));
        end
        drive_heads();
        out_avail = '1;
        #1;
        chk("reset out_data", out_data, '0);
        chk("reset in_shift", (NP*PL)'(in_shift), '0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // All five contend for Local: rotation 0,1,2,3,4,0,...
        repeat (12) cycle(0, 100, '0);

        // One packet to each direction; distinct outputs grant in parallel.
        srcq[0].push_back(make_pkt(2, 0));
        srcq[1].push_back(make_pkt(0, 2));
        srcq[2].push_back(make_pkt(1, 0));
        srcq[3].push_back(make_pkt(1, 2));
        srcq[4].push_back(make_pkt(1, 1));
        repeat (3) cycle(0, 100, '0);

        // East blocked for six cycles with several East requesters.
        for (int i = 0; i < 3; i++) begin
            srcq[i].push_back(make_pkt(2, $urandom_range(2)));
        end
        repeat (6) cycle(0, 100, 5'b00100);
        repeat (4) cycle(0, 100, '0);

        // Random traffic with random backpressure.
        repeat (400) cycle(40, 70, '0);

        // Fill slots with downstream full, then reset mid-transfer.
        repeat (4) cycle(60, 0, '0);
        do_reset();
        repeat (200) cycle(40, 70, '0);

        // Drain, bounded.
        drained = 1'b0;
        for (int c = 0; c < 100 && !drained; c++) begin
            cycle(0, 100, '0);
            drained = 1'b1;
            for (int i = 0; i < NP; i++) begin
                if (srcq[i].size() != 0 || m_slot[i][0]) drained = 1'b0;
            end
        end
        if (!drained) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got still busy after 100 cycles, expected idle");
        end
        for (int o = 0; o < NP; o++) begin
            chk($sformatf("out%0d leftover", o), (NP*PL)'(expq[o].size()), '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
